data_ram_loader: RTL and testbench
==================================

// Module: data_ram_loader
// PURPOSE
// - Upstream feeder of the 24-bit multicycle CPU. Takes a byte stream from the UART receiver,
//   assembles 24-bit words, and writes them into the shared data RAM.
// - While loading, it owns the RAM write port. After the frame completes it asserts receive_done,
//   the CPU's chk_receive_done, and passes the CPU memory port through unchanged.
// PARAMETERS
// - DATA_AW      14      data RAM word-address width; must match the CPU DATA_AW
// - BASE_ADDR    0       RAM word address of the first loaded word
// - SYNC_BYTE    8'hA5   frame start marker
// - TIMEOUT_CYC  100000  maximum idle clocks between bytes inside a frame
// PORTS
// - clk           in   1        system clock, rising edge
// - rst_n         in   1        asynchronous, active-low reset
// - rx_valid      in   1        one-cycle strobe: rx_data holds a received byte
// - rx_data       in   8        received byte
// - cpu_mem_we    in   1        CPU mem_we_ext
// - cpu_mem_addr  in   DATA_AW  CPU mem_addr_ext
// - cpu_mem_din   in   24       CPU mem_data_in_ext
// - ram_we        out  1        data RAM write enable
// - ram_addr      out  DATA_AW  data RAM address
// - ram_din       out  24       data RAM write data
// - receive_done  out  1        frame fully written; drives CPU chk_receive_done
// - frame_err     out  1        sticky: timeout or address wrap seen; cleared at next SYNC
// - words_loaded  out  DATA_AW  words written in the current/last frame
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; receive_done=0, frame_err=0, words_loaded=0,
//   ram_we=0, ram_addr=0, ram_din=0; all byte and count registers cleared.
// - Frame format: SYNC, LEN_HI, LEN_LO, then LEN words. Each word is 3 bytes, MS byte first.
//   LEN is 16 bits; only LEN[DATA_AW-1:0] is used.
// - FSM states: IDLE, LEN_H, LEN_L, B2, B1, B0, DONE. Transitions occur only on rx_valid,
//   except the timeout transition.
//   - IDLE: SYNC -> LEN_H and clear frame_err, words_loaded. Any other byte is ignored.
//   - LEN_H -> LEN_L. LEN_L -> B2, or -> DONE if LEN==0.
//   - B2 -> B1 -> B0. On the byte in B0: word = {b2,b1,rx_data}, wr_pend=1;
//     -> B2, or -> DONE if this was word LEN.
//   - DONE: receive_done=1. A SYNC byte -> LEN_H, receive_done=0 next cycle
//     (reload; the CPU stalls PC). Other bytes are ignored.
// - Write timing: the cycle after the B0 byte, ram_we=1 for exactly 1 cycle,
//   ram_addr = BASE_ADDR + words_loaded (mod 2^DATA_AW), ram_din = word.
//   words_loaded increments in that same cycle. A byte arriving during the write cycle is
//   accepted normally; there is no backpressure.
// - Wrap: if BASE_ADDR+LEN > 2^DATA_AW, addresses wrap modulo 2^DATA_AW, loading continues,
//   and frame_err=1.
// - Timeout: in LEN_H..B0, an idle counter counts clocks since the last byte. It resets on
//   every rx_valid. When it reaches TIMEOUT_CYC: frame_err=1, state -> IDLE, receive_done
//   stays 0. Words already written stay in RAM.
// - Port mux: when state!=DONE, ram_* are driven by loader registers and cpu_mem_* are ignored
//   (CPU writes dropped). When state==DONE, ram_we/addr/din = cpu_mem_we/addr/din
//   combinationally, with zero added latency.
// - The final-word write completes (wr_pend) before DONE takes the port. DONE is entered in
//   the write cycle, but the loader write has priority in that single cycle.
// - Reset mid-frame aborts immediately. RAM contents are not cleared.
// STRUCTURE
// - Shared package (cpu24_pkg): SYNC_BYTE default, loader state encoding, word width 24.
// - One sub-module: loader_timeout_ctr (idle counter, clear/expire), sized by $clog2(TIMEOUT_CYC+1).
// - Port mux and byte assembler stay inline.
// TESTING
// - Reset then A5,00,02,11,22,33,44,55,66 -> writes 0x112233@0, 0x445566@1; receive_done=1
//   one cycle after the 2nd write; words_loaded=2.
// - A5,00,00 -> DONE without any ram_we; receive_done=1; frame_err=0.
// - Bytes 00,FF before A5 are ignored. A5,00,01 then silence for TIMEOUT_CYC
//   -> frame_err=1, IDLE, receive_done=0, no write.
// - In DONE, drive cpu_mem_we=1, addr=5, din=0xABCDEF -> ram_* mirrors in the same cycle.
//   Before DONE, the same CPU write is dropped.
// - BASE_ADDR=2^DATA_AW-1, LEN=2 -> writes at max address then 0; frame_err=1;
//   receive_done=1.
// - In DONE, send A5 -> receive_done falls next cycle. Assert rst_n=0 mid-word
//   -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU subsystem and its data RAM loader.
package cpu24_pkg;

  localparam int         WORD_W        = 24;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN_H = 3'd1,
    LEN_L = 3'd2,
    B2    = 3'd3,
    B1    = 3'd4,
    B0    = 3'd5,
    DONE  = 3'd6
  } loader_state_t;

  // True while a frame is being received and the idle timeout applies.
  function automatic logic is_frame_state(input loader_state_t s);
    return (s == LEN_H) || (s == LEN_L) || (s == B2) || (s == B1) || (s == B0);
  endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Idle-clock counter for the loader: expires on the clock that would make the
// number of idle cycles since the last byte reach TIMEOUT_CYC.
module loader_timeout_ctr #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/data_ram_loader.sv
// Assembles 24-bit words from a framed UART byte stream, writes them into the
// shared data RAM, then passes the CPU memory port through once the frame is done.
module data_ram_loader
  import cpu24_pkg::*;
#(
  parameter int         DATA_AW     = 14,
  parameter int         BASE_ADDR   = 0,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               cpu_mem_we,
  input  logic [DATA_AW-1:0] cpu_mem_addr,
  input  logic [WORD_W-1:0]  cpu_mem_din,
  output logic               ram_we,
  output logic [DATA_AW-1:0] ram_addr,
  output logic [WORD_W-1:0]  ram_din,
  output logic               receive_done,
  output logic               frame_err,
  output logic [DATA_AW-1:0] words_loaded
);
  localparam logic [DATA_AW:0] BASE_EXT = (DATA_AW + 1)'(BASE_ADDR);

  loader_state_t      state_reg;
  logic [7:0]         len_hi_reg;
  logic [7:0]         b2_reg;
  logic [7:0]         b1_reg;
  logic [DATA_AW-1:0] len_reg;
  logic [DATA_AW-1:0] words_loaded_reg;
  logic [DATA_AW-1:0] wr_addr_reg;
  logic [WORD_W-1:0]  wr_din_reg;
  logic               wr_we_reg;
  logic               frame_err_reg;
  logic               receive_done_reg;

  logic               is_sync;
  logic               tmo_expired;
  logic               last_word;
  logic [DATA_AW-1:0] len_now;
  logic [DATA_AW:0]   addr_sum;

  assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
  // Only the low DATA_AW bits of the 16-bit length are meaningful.
  assign len_now   = DATA_AW'({len_hi_reg, rx_data});
  // The extra MSB flags an address that wrapped past the top of the RAM.
  assign addr_sum  = {1'b0, words_loaded_reg} + BASE_EXT;
  assign last_word = (words_loaded_reg + DATA_AW'(1)) == len_reg;

  loader_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (is_frame_state(state_reg)),
    .clr    (rx_valid),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      len_hi_reg       <= '0;
      b2_reg           <= '0;
      b1_reg           <= '0;
      len_reg          <= '0;
      words_loaded_reg <= '0;
      wr_addr_reg      <= '0;
      wr_din_reg       <= '0;
      wr_we_reg        <= 1'b0;
      frame_err_reg    <= 1'b0;
      receive_done_reg <= 1'b0;
    end else begin
      wr_we_reg        <= 1'b0;
      // Rises one cycle after DONE is entered, so the final write has landed.
      receive_done_reg <= (state_reg == DONE) && !is_sync;
      if (tmo_expired) begin
        state_reg     <= IDLE;
        frame_err_reg <= 1'b1;
      end else if (rx_valid) begin
        unique case (state_reg)
          IDLE, DONE: begin
            if (is_sync) begin
              state_reg        <= LEN_H;
              frame_err_reg    <= 1'b0;
              words_loaded_reg <= '0;
            end
          end
          LEN_H: begin
            len_hi_reg <= rx_data;
            state_reg  <= LEN_L;
          end
          LEN_L: begin
            len_reg   <= len_now;
            state_reg <= (len_now == '0) ? DONE : B2;
          end
          B2: begin
            b2_reg    <= rx_data;
            state_reg <= B1;
          end
          B1: begin
            b1_reg    <= rx_data;
            state_reg <= B0;
          end
          B0: begin
            wr_we_reg        <= 1'b1;
            wr_addr_reg      <= addr_sum[DATA_AW-1:0];
            wr_din_reg       <= {b2_reg, b1_reg, rx_data};
            words_loaded_reg <= words_loaded_reg + DATA_AW'(1);
            if (addr_sum[DATA_AW]) begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= last_word ? DONE : B2;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // The pending loader write keeps the port for the one cycle DONE overlaps it.
  always_comb begin
    ram_we   = wr_we_reg;
    ram_addr = wr_addr_reg;
    ram_din  = wr_din_reg;
    if ((state_reg == DONE) && !wr_we_reg) begin
      ram_we   = cpu_mem_we;
      ram_addr = cpu_mem_addr;
      ram_din  = cpu_mem_din;
    end
  end

  assign receive_done = receive_done_reg;
  assign frame_err    = frame_err_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_data_ram_loader.sv
// Randomised scoreboard bench for data_ram_loader with a top-of-RAM base address.
module tb_data_ram_loader;
  localparam int AW   = 4;
  localparam int BASE = 15;
  localparam int TMO  = 40;
  localparam int RAMW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          cpu_mem_we;
  logic [AW-1:0] cpu_mem_addr;
  logic [23:0]   cpu_mem_din;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_din;
  logic          receive_done;
  logic          frame_err;
  logic [AW-1:0] words_loaded;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  data_ram_loader #(
    .DATA_AW    (AW),
    .BASE_ADDR  (BASE),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cpu_mem_we  (cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_din (cpu_mem_din),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .receive_done(receive_done),
    .frame_err   (frame_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every RAM write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n === 1'b1 && ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 ram_addr, ram_din, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ram_addr), 32'(e.addr));
        check("write_data", 32'(ram_din), 32'(e.data));
        $display("write addr=0x%0h data=0x%06h", ram_addr, ram_din);
      end
    end
  end

  function automatic int rg(input int m);
    return int'($urandom_range(m, 0));
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte and `gap` idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input int idx, input logic [23:0] w, input int maxgap, input bit last);
    wr_t e;
    e.addr = AW'((BASE + idx) % RAMW);
    e.data = w;
    send_byte(w[23:16], rg(maxgap));
    send_byte(w[15:8], rg(maxgap));
    exp_q.push_back(e);
    send_byte(w[7:0], last ? 0 : rg(maxgap));
  endtask

  task automatic check_done(input int n);
    check("done_latency", 32'(receive_done), 32'(0));
    @(posedge clk); #1;
    check("receive_done", 32'(receive_done), 32'(1));
    check("frame_err", 32'(frame_err), 32'((BASE + n) > RAMW));
    check("words_loaded", 32'(words_loaded), 32'(n));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("frame len=%0d done rd=%0b err=%0b words=%0d", n, receive_done, frame_err, words_loaded);
  endtask

  task automatic run_frame(input logic [15:0] len16, input int maxgap);
    int n;
    n = int'(len16) % RAMW;
    send_byte(8'hA5, rg(maxgap));
    send_byte(len16[15:8], rg(maxgap));
    send_byte(len16[7:0], (n == 0) ? 0 : rg(maxgap));
    for (int i = 0; i < n; i++) send_word(i, 24'($urandom), maxgap, i == n - 1);
    check_done(n);
  endtask

  task automatic run_timeout(input logic [15:0] len16, input int nw, input int np);
    send_byte(8'hA5, rg(2));
    send_byte(len16[15:8], rg(2));
    send_byte(len16[7:0], (nw == 0 && np == 0) ? 0 : rg(2));
    for (int i = 0; i < nw; i++) send_word(i, 24'($urandom), 2, (i == nw - 1) && (np == 0));
    for (int j = 0; j < np; j++) send_byte(8'($urandom), (j == np - 1) ? 0 : rg(2));
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", 32'(frame_err), 32'((BASE + nw) > RAMW));
    @(posedge clk); #1;
    check("tmo_frame_err", 32'(frame_err), 32'(1));
    check("tmo_receive_done", 32'(receive_done), 32'(0));
    check("tmo_words_loaded", 32'(words_loaded), 32'(nw));
    check("tmo_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("timeout words=%0d partial=%0d err=%0b", nw, np, frame_err);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [23:0] d, input bit pass);
    wr_t e;
    cpu_mem_we   = 1'b1;
    cpu_mem_addr = a;
    cpu_mem_din  = d;
    if (pass) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    #1;
    check("cpu_we_mux", 32'(ram_we), 32'(pass));
    if (pass) begin
      check("cpu_addr_mux", 32'(ram_addr), 32'(a));
      check("cpu_din_mux", 32'(ram_din), 32'(d));
    end
    $display("cpu write addr=0x%0h data=0x%06h pass=%0b", a, d, pass);
    @(posedge clk); #1;
    cpu_mem_we   = 1'b0;
    cpu_mem_addr = AW'($urandom);
    cpu_mem_din  = 24'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 32'(0));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_ram_din"}, 32'(ram_din), 32'(0));
    check({tag, "_receive_done"}, 32'(receive_done), 32'(0));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(0));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(0));
    $display("%s reset outputs checked", tag);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion, expected $finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] g;
    rst_n        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    cpu_mem_we   = 1'b1;
    cpu_mem_addr = 4'h7;
    cpu_mem_din  = 24'h123456;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    cpu_mem_we = 1'b0;
    @(posedge clk); #1;

    // Noise before a SYNC is ignored, and the CPU cannot write before DONE.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    check("idle_words", 32'(words_loaded), 32'(0));
    check("idle_receive_done", 32'(receive_done), 32'(0));
    cpu_write(4'h5, 24'hABCDEF, 1'b0);

    // A5,00,01 then silence: timeout with no write.
    run_timeout(16'h0001, 0, 0);

    // Reference frame: two words, wraps from the top address to 0.
    send_byte(8'hA5, 1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 2);
    send_word(0, 24'h112233, 1, 1'b0);
    send_word(1, 24'h445566, 1, 1'b1);
    check_done(2);

    // CPU port passes through in DONE.
    cpu_write(4'h5, 24'hABCDEF, 1'b1);

    // Reload from DONE, then an empty frame.
    send_byte(8'hA5, 0);
    check("reload_receive_done", 32'(receive_done), 32'(0));
    check("reload_frame_err", 32'(frame_err), 32'(0));
    check("reload_words", 32'(words_loaded), 32'(0));
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
    check_done(0);

    // CPU write mid-frame is dropped; single word does not wrap.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    cpu_write(4'h3, 24'h0F0F0F, 1'b0);
    send_byte(8'h01, 1);
    send_word(0, 24'hC0FFEE, 1, 1'b1);
    check_done(1);

    // Truncated frames: words already written stay counted.
    run_timeout(16'h0003, 1, 1);
    run_timeout(16'h0005, 2, 2);

    // Randomised frames with CPU traffic and noise while DONE.
    for (int f = 0; f < 12; f++) begin
      run_frame(16'($urandom), 3);
      for (int k = 0; k < rg(2); k++) cpu_write(AW'($urandom), 24'($urandom), 1'b1);
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, 1);
      check("done_ignores_noise", 32'(receive_done), 32'(1));
    end

    // Asynchronous reset in the middle of a word.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(0, 24'h445566, 1, 1'b0);
    send_byte(8'h11, 0);
    check("pre_reset_words", 32'(words_loaded), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(16'h0003, 2);

    repeat (3) @(posedge clk);
    #1 check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
